// File: rtl/diff_codec_pkg.sv
`default_nettype none
// ============================================================================
// Module : diff_codec_pkg
// Brief  : Shared widths and FSM encoding for the bit-serial diff decoder.
// Rev    : 1.0  initial release
// ============================================================================
package diff_codec_pkg;

    localparam int c_op_w  = 4;
    localparam int c_res_w = 6;
    localparam int c_cnt_w = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module : full_adder
// Brief  : Single-bit full adder cell.
// Rev    : 1.0  initial release
// ============================================================================
module full_adder (
    input  logic c_in,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic c_out
);

    logic w_p;

    assign w_p   = a ^ b;
    assign sum   = w_p ^ c_in;
    assign c_out = (a & b) | (c_in & w_p);

endmodule
`default_nettype wire

// File: rtl/diff_decoder.sv
`default_nettype none
// ============================================================================
// Module : diff_decoder
// Brief  : Bit-serial reconstruction of a = b + diff from a sign-magnitude
//          difference, one full-adder bit per cycle, with range flag.
// Rev    : 1.0  initial release
// ============================================================================
module diff_decoder
    import diff_codec_pkg::*;
#(
    parameter int W_OP  = c_op_w,
    parameter int W_RES = c_res_w
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_OP-1:0]  b,
    input  logic             diff_sign,
    input  logic [W_OP-1:0]  diff_mag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_RES-1:0] a_out,
    output logic             out_of_range
);

    state_e             r_state;
    logic [W_RES-1:0]   r_b;
    logic [W_RES-1:0]   r_d;
    logic [W_RES-1:0]   r_res;
    logic [W_RES-1:0]   r_a_out;
    logic               r_oor;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_sum;
    logic               w_cout;
    logic               w_last;
    logic [W_RES-1:0]   w_res_next;

    full_adder u_fa (
        .c_in  (r_carry),
        .a     (r_b[0]),
        .b     (r_d[0]),
        .sum   (w_sum),
        .c_out (w_cout)
    );

    assign w_last     = (r_cnt == c_cnt_w'(W_RES - 1));
    assign w_res_next = {w_sum, r_res[W_RES-1:1]};

    assign in_ready     = (r_state == IDLE);
    assign out_valid    = (r_state == DONE);
    assign a_out        = r_a_out;
    assign out_of_range = r_oor;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_b     <= '0;
            r_d     <= '0;
            r_res   <= '0;
            r_a_out <= '0;
            r_oor   <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // Negation as ones' complement plus the carry-in seed.
                        r_b     <= {{(W_RES-W_OP){1'b0}}, b};
                        r_d     <= {{(W_RES-W_OP){1'b0}}, diff_mag} ^ {W_RES{diff_sign}};
                        r_carry <= diff_sign;
                        r_cnt   <= '0;
                        r_res   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_res   <= w_res_next;
                    r_b     <= r_b >> 1;
                    r_d     <= r_d >> 1;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_a_out <= w_res_next;
                        r_oor   <= w_res_next[W_RES-1] | w_res_next[W_RES-2];
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_diff_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_diff_decoder
// Brief  : Directed self-checking bench for diff_decoder.
// Rev    : 1.0  initial release
// ============================================================================
module tb_diff_decoder;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] b;
    logic       diff_sign;
    logic [3:0] diff_mag;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] a_out;
    logic       out_of_range;

    int n_cmp;
    int n_err;
    int cyc;
    int prev_acc;
    bit have_prev;

    diff_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .b            (b),
        .diff_sign    (diff_sign),
        .diff_mag     (diff_mag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .a_out        (a_out),
        .out_of_range (out_of_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One request; hold=1 leaves out_ready low so the result parks in DONE.
    task automatic run_one(input string tag, input logic [3:0] vb, input logic vs,
                           input logic [3:0] vm, input bit hold, input bit chk_tp);
        int n;
        int a;
        a = int'(vb) + (vs ? -int'(vm) : int'(vm));
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        b         = vb;
        diff_sign = vs;
        diff_mag  = vm;
        in_valid  = 1'b1;
        out_ready = !hold;
        @(posedge clk); #1;
        if (chk_tp && have_prev) chk({tag, "_period"}, 32'(cyc - prev_acc), 32'd8);
        prev_acc  = cyc;
        have_prev = 1'b1;
        in_valid  = 1'b0;
        b         = ~vb;
        diff_sign = ~vs;
        diff_mag  = ~vm;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd6);
        chk({tag, "_a"}, 32'(a_out), 32'(a & 63));
        chk({tag, "_oor"}, 32'(out_of_range), 32'((a < 0 || a > 15) ? 1 : 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        n_cmp     = 0;
        n_err     = 0;
        have_prev = 1'b0;
        prev_acc  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        b         = '0;
        diff_sign = 1'b0;
        diff_mag  = '0;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_a_out", 32'(a_out), 32'd0);
        chk("rst_oor", 32'(out_of_range), 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        run_one("v5p3", 4'd5, 1'b0, 4'd3, 1'b0, 1'b0);
        chk("v5p3_abs", 32'(a_out), 32'd8);
        run_one("v3m7", 4'd3, 1'b1, 4'd7, 1'b0, 1'b0);
        chk("v3m7_abs", 32'(a_out), 32'b111100);
        run_one("v15p15", 4'd15, 1'b0, 4'd15, 1'b0, 1'b0);
        chk("v15p15_abs", 32'(a_out), 32'd30);

        // Back-pressure: result parks, stray request must not be queued.
        run_one("bp", 4'd7, 1'b0, 4'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            b        = 4'd1;
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_a", 32'(a_out), 32'd9);
            chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_xfer_valid", 32'(out_valid), 32'd0);
        chk("bp_xfer_rdy", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen++;
        end
        chk("bp_not_queued", 32'(seen), 32'd0);

        // Negative zero; leaves a nonzero a_out so the reset clear is visible.
        run_one("negz", 4'd9, 1'b1, 4'd0, 1'b0, 1'b0);
        chk("negz_abs", 32'(a_out), 32'd9);

        b         = 4'd12;
        diff_sign = 1'b0;
        diff_mag  = 4'd1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_a_out", 32'(a_out), 32'd0);
        chk("mrst_oor", 32'(out_of_range), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk) reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("mrst_no_valid", 32'(seen), 32'd0);
        run_one("after_rst", 4'd2, 1'b0, 4'd4, 1'b0, 1'b0);
        chk("after_rst_abs", 32'(a_out), 32'd6);

        have_prev = 1'b0;
        for (int vb = 0; vb < 16; vb++)
            for (int vs = 0; vs < 2; vs++)
                for (int vm = 0; vm < 16; vm++)
                    run_one("exh", 4'(vb), 1'(vs), 4'(vm), 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
